// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-size encodings, round counts,
// default store geometry and the round-key store state encoding.
package aes_pkg;

  localparam int KEY_W = 128;
  localparam int DEPTH = 15;

  localparam logic [1:0] NK_4    = 2'd0;
  localparam logic [1:0] NK_6    = 2'd1;
  localparam logic [1:0] NK_8    = 2'd2;
  localparam logic [1:0] NK_RSVD = 2'd3;

  localparam logic [3:0] NR_NK4 = 4'd10;
  localparam logic [3:0] NR_NK6 = 4'd12;
  localparam logic [3:0] NR_NK8 = 4'd14;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  function automatic logic [3:0] nr_of(input logic [1:0] nk);
    case (nk)
      NK_6:    nr_of = NR_NK6;
      NK_8:    nr_of = NR_NK8;
      default: nr_of = NR_NK4;
    endcase
  endfunction

endpackage

// File: rtl/round_key_regfile.sv
// Round-key storage: DEPTH x KEY_W, one write port, one registered read port.
// Contents are deliberately not reset; the controller gates visibility.
module round_key_regfile #(
  parameter int KEY_W = 128,
  parameter int DEPTH = 15
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       wr_idx,
  input  logic [KEY_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_data
);

  logic [KEY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (int'(wr_idx) < DEPTH)) begin
      mem[wr_idx] <= wr_data;
    end
    if (rd_en && (int'(rd_idx) < DEPTH)) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/round_key_store.sv
// Round-key store: captures a full AES key schedule from key expansion and
// serves single-cycle-latency reads, flagging protocol errors stickily.
module round_key_store
  import aes_pkg::*;
#(
  parameter int KEY_W = aes_pkg::KEY_W,
  parameter int DEPTH = aes_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       in_nk,
  input  logic             in_start,
  input  logic             in_key_valid,
  input  logic             in_key_first,
  input  logic             in_key_last,
  input  logic [KEY_W-1:0] in_key,
  input  logic             in_rd_en,
  input  logic [3:0]       in_rd_idx,
  output logic             out_rd_valid,
  output logic [KEY_W-1:0] out_rd_key,
  output logic             out_busy,
  output logic             out_ready,
  output logic [3:0]       out_nr,
  output logic             out_err
);

  state_t     state, state_nx;
  logic [1:0] nk_q, nk_nx;
  logic [3:0] wr_ptr, wr_ptr_nx;
  logic       err_q, err_nx;
  logic       loaded_q, loaded_nx;
  logic       rd_valid_q;
  logic       we;
  logic [3:0] wr_idx;
  logic       rd_hit;
  logic [3:0] nr;
  logic [KEY_W-1:0] rd_data;

  assign nr = nr_of(nk_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      nk_q       <= NK_4;
      wr_ptr     <= 4'd0;
      err_q      <= 1'b0;
      loaded_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= state_nx;
      nk_q       <= nk_nx;
      wr_ptr     <= wr_ptr_nx;
      err_q      <= err_nx;
      loaded_q   <= loaded_nx;
      rd_valid_q <= rd_hit;
    end
  end

  // A start always wins over a coincident key; a key_first rewinds to entry 0.
  always_comb begin
    state_nx  = state;
    nk_nx     = nk_q;
    wr_ptr_nx = wr_ptr;
    err_nx    = err_q;
    loaded_nx = loaded_q;
    we        = 1'b0;
    wr_idx    = in_key_first ? 4'd0 : wr_ptr;

    if (in_start) begin
      if (in_nk != NK_RSVD) begin
        nk_nx     = in_nk;
        wr_ptr_nx = 4'd0;
        err_nx    = 1'b0;
        loaded_nx = 1'b1;
        state_nx  = ST_FILL;
      end else begin
        err_nx   = 1'b1;
        state_nx = ST_EMPTY;
      end
    end else if ((state == ST_FILL) && in_key_valid) begin
      if (!in_key_first && (wr_ptr > nr)) begin
        err_nx = 1'b1;
      end else begin
        we        = 1'b1;
        wr_ptr_nx = wr_idx + 4'd1;
        if (in_key_last) begin
          if (wr_idx == nr) begin
            state_nx = ST_READY;
          end else begin
            err_nx   = 1'b1;
            state_nx = ST_EMPTY;
          end
        end
      end
    end
  end

  // An entry being written this cycle is not yet committed, so it reads invalid.
  always_comb begin
    rd_hit = 1'b0;
    if (in_rd_en && !(we && (wr_idx == in_rd_idx))) begin
      if ((state == ST_READY) && (in_rd_idx <= nr)) begin
        rd_hit = 1'b1;
      end else if ((state == ST_FILL) && (in_rd_idx < wr_ptr)) begin
        rd_hit = 1'b1;
      end
    end
  end

  round_key_regfile #(
    .KEY_W (KEY_W),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk     (clk),
    .we      (we),
    .wr_idx  (wr_idx),
    .wr_data (in_key),
    .rd_en   (rd_hit),
    .rd_idx  (in_rd_idx),
    .rd_data (rd_data)
  );

  assign out_rd_valid = rd_valid_q;
  assign out_rd_key   = rd_valid_q ? rd_data : '0;
  assign out_busy     = (state == ST_FILL);
  assign out_ready    = (state == ST_READY);
  assign out_nr       = loaded_q ? nr : 4'd0;
  assign out_err      = err_q;

endmodule

// File: doc/round_key_store.md
ROUND_KEY_STORE -- requirements
Module: round_key_store

Interface
REQ-001 SHALL have parameter KEY_W, default 128, round-key width in bits.
REQ-002 SHALL have parameter DEPTH, default 15, number of round-key entries (max Nr+1).
REQ-003 SHALL have port clk  input  1  single clock; all flops rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_nk  input  2  key size: 0=Nk4, 1=Nk6, 2=Nk8, 3=reserved.
REQ-006 SHALL have port in_start  input  1  begin new key load; clears store.
REQ-007 SHALL have port in_key_valid  input  1  round key present on in_key.
REQ-008 SHALL have port in_key_first  input  1  qualifies first round key (entry 0).
REQ-009 SHALL have port in_key_last  input  1  qualifies final round key.
REQ-010 SHALL have port in_key  input  KEY_W  round-key data from key expansion.
REQ-011 SHALL have port in_rd_en  input  1  read request.
REQ-012 SHALL have port in_rd_idx  input  4  round index to read.
REQ-013 SHALL have port out_rd_valid  output  1  out_rd_key holds requested key.
REQ-014 SHALL have port out_rd_key  output  KEY_W  read data.
REQ-015 SHALL have port out_busy  output  1  FILL state.
REQ-016 SHALL have port out_ready  output  1  READY state; full schedule stored.
REQ-017 SHALL have port out_nr  output  4  Nr of latched nk: 10/12/14.
REQ-018 SHALL have port out_err  output  1  sticky protocol error.

Function
REQ-019 SHALL implement FSM states EMPTY, FILL, READY; out_busy=(FILL), out_ready=(READY).
REQ-020 In any state, in_start with in_nk!=3 SHALL latch nk, clear wr_ptr and out_err, enter FILL next cycle.
REQ-021 in_start with in_nk==3 SHALL set out_err and enter EMPTY.
REQ-022 In FILL, in_key_valid SHALL write in_key to entry wr_ptr and increment wr_ptr (4-bit).
REQ-023 in_key_valid with in_key_first SHALL write entry 0 and set wr_ptr=1, regardless of prior wr_ptr.
REQ-024 in_key_valid with in_key_last and written index == Nr SHALL enter READY next cycle.
REQ-025 in_key_last with written index != Nr SHALL set out_err and enter EMPTY.
REQ-026 in_key_valid when wr_ptr > Nr SHALL be discarded and set out_err; state stays FILL.
REQ-027 in_key_valid in EMPTY or READY SHALL be ignored with no error.
REQ-028 in_start coincident with in_key_valid SHALL take priority; the key is discarded.
REQ-029 Read latency SHALL be 1 cycle: in_rd_en at cycle N -> out_rd_valid/out_rd_key at N+1.
REQ-030 Read SHALL be valid iff (READY and idx<=Nr) or (FILL and idx<wr_ptr), else out_rd_valid=0, out_rd_key=0.
REQ-031 Write and read of the same entry in one cycle SHALL return out_rd_valid=0 (entry not yet committed).
REQ-032 out_rd_valid SHALL be 0 in cycles following in_rd_en=0.
REQ-033 out_nr SHALL equal 10/12/14 for latched nk 0/1/2, 0 in EMPTY after reset.

Reset
REQ-034 rst_n low SHALL asynchronously force EMPTY, wr_ptr=0, latched nk=0, out_err=0, out_rd_valid=0, out_rd_key=0, out_nr=0.
REQ-035 Key storage array SHALL NOT be reset; contents unreachable until rewritten (REQ-030).
REQ-036 Reset asserted mid-FILL SHALL abandon the load; no partial READY after release.

Structure
REQ-037 Shared package aes_pkg SHALL hold NK encodings, NR_NK4/6/8 constants, KEY_W, DEPTH and the state enum.
REQ-038 Storage SHALL be a sub-module round_key_regfile (DEPTH x KEY_W, 1 write, 1 registered read).

Verification
REQ-039 Nk4 load: start, 11 valid keys (first on #0, last on #10) -> out_ready=1, out_nr=10, reads idx 0..10 return written data at +1 cycle.
REQ-040 Nk8 load of 15 keys, then read idx 15 -> out_rd_valid=0, out_rd_key=0; out_err=0.
REQ-041 Nk6 with in_key_last on 10th key -> out_err=1, state EMPTY, read idx 0 -> out_rd_valid=0.
REQ-042 Mid-fill read: Nk4 after 5 keys, read idx 4 -> valid; read idx 5 -> invalid; same-cycle write/read idx 5 -> invalid.
REQ-043 in_start during READY with in_key_valid same cycle -> out_ready=0 next cycle, key discarded, wr_ptr=0.
REQ-044 rst_n pulsed low mid-cycle during FILL -> outputs zero immediately, EMPTY after release; in_nk=3 start -> out_err=1.
